// File: rtl/mire_pkg.sv
// Shared types and colour constants for the grid test-pattern ("mire") writer.
package mire_pkg;

  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    WRITE   = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

endpackage

// File: rtl/mire_pixel_gen.sv
// Combinational pattern source: maps pixel (x,y) to a 24-bit colour.
// Grid lines every GRID pixels plus a border on the last column and last row.
module mire_pixel_gen
  import mire_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int GRID  = 16,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic [23:0]   rgb_o
);

  logic on_line;

  always_comb begin
    on_line = ((32'(x_i) & 32'(GRID - 1)) == 32'd0) ||
              ((32'(y_i) & 32'(GRID - 1)) == 32'd0) ||
              (x_i == XW'(HDISP - 1)) ||
              (y_i == YW'(VDISP - 1));
    rgb_o = on_line ? WHITE : BLACK;
  end

endmodule

// File: rtl/wshb_mire.sv
// Wishbone write master painting a grid pattern into the framebuffer, one pixel per transaction.
// Build option: define MIRE_LOOP_EN to repaint the frame continuously instead of stopping in DONE.
module wshb_mire
  import mire_pkg::*;
#(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          BURST_LEN = 64,
  parameter int          GRID      = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic [3:0]  sel,
  input  logic        ack,
  input  logic [31:0] dat_sm,
  output logic        frame_done
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  state_e        state_q;
  logic [XW-1:0] x_q, x_d, pg_x;
  logic [YW-1:0] y_q, y_d, pg_y;
  logic [BW-1:0] burst_q, burst_d;
  logic [31:0]   adr_q, dat_q;
  logic          cyc_q, done_q;
  logic          x_last, y_last;
  logic [23:0]   pix;
  logic          unused_dat;

  assign unused_dat = ^dat_sm;

  always_comb begin
    x_last  = (x_q == XW'(HDISP - 1));
    y_last  = (y_q == YW'(VDISP - 1));
    x_d     = x_last ? '0 : x_q + 1'b1;
    y_d     = x_last ? (y_last ? '0 : y_q + 1'b1) : y_q;
    burst_d = burst_q + 1'b1;
    // In WRITE the colour is prepared for the pixel that follows the ack;
    // in RELEASE it is (re)loaded for the pixel about to be presented.
    pg_x    = (state_q == WRITE) ? x_d : x_q;
    pg_y    = (state_q == WRITE) ? y_d : y_q;
  end

  mire_pixel_gen #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .GRID  (GRID),
    .XW    (XW),
    .YW    (YW)
  ) u_pixel_gen (
    .x_i   (pg_x),
    .y_i   (pg_y),
    .rgb_o (pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELEASE;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      adr_q   <= BASE_ADDR;
      dat_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      burst_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RELEASE: begin
          state_q <= WRITE;
          cyc_q   <= 1'b1;
          dat_q   <= {8'h00, pix};
        end
        WRITE: begin
          if (cyc_q && ack) begin
            dat_q <= {8'h00, pix};
            if (x_last && y_last) begin
              // End of frame also closes any burst: one release, everything restarts.
              done_q  <= 1'b1;
              cyc_q   <= 1'b0;
              x_q     <= '0;
              y_q     <= '0;
              burst_q <= '0;
              adr_q   <= BASE_ADDR;
`ifdef MIRE_LOOP_EN
              state_q <= RELEASE;
`else
              state_q <= DONE;
`endif
            end else begin
              x_q   <= x_d;
              y_q   <= y_d;
              adr_q <= adr_q + 32'd4;
              if (burst_d == BW'(BURST_LEN)) begin
                burst_q <= '0;
                cyc_q   <= 1'b0;
                state_q <= RELEASE;
              end else begin
                burst_q <= burst_d;
              end
            end
          end
        end
        default: begin
          cyc_q <= 1'b0;
        end
      endcase
    end
  end

  assign cyc        = cyc_q;
  assign stb        = cyc_q;
  assign we         = 1'b1;
  assign sel        = 4'hF;
  assign adr        = adr_q;
  assign dat_ms     = dat_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_wshb_mire.sv
// Directed bench for wshb_mire on a 32x4 frame with a latency-configurable RAM slave.
module tb_wshb_mire;

  localparam int          HDISP = 32;
  localparam int          VDISP = 4;
  localparam int          BLEN  = 8;
  localparam int          GRID  = 16;
  localparam int          NPIX  = HDISP * VDISP;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] W     = 32'h00FF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc, stb, we, ack, frame_done;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [31:0] dat_sm = 32'h0;

  int lat = 0;
  int wcnt = 0;
  int ack_cnt = 0;
  int seq_err = 0;
  logic [31:0] last_adr = 32'h0;
  logic [31:0] ram [0:NPIX-1];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  wshb_mire #(
    .HDISP     (HDISP),
    .VDISP     (VDISP),
    .BASE_ADDR (BASE),
    .BURST_LEN (BLEN),
    .GRID      (GRID)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cyc        (cyc),
    .stb        (stb),
    .we         (we),
    .adr        (adr),
    .dat_ms     (dat_ms),
    .sel        (sel),
    .ack        (ack),
    .dat_sm     (dat_sm),
    .frame_done (frame_done)
  );

  function automatic logic [31:0] exp_pix(input int idx);
    int x, y;
    x = idx % HDISP;
    y = idx / HDISP;
    return ((x % GRID == 0) || (y % GRID == 0) || (x == HDISP - 1) || (y == VDISP - 1)) ? W : 32'h0;
  endfunction

  // Slave: ack after 'lat' wait cycles of a held strobe.
  assign ack = stb && (wcnt >= lat);

  always @(posedge clk) begin
    if (!stb || ack) wcnt <= 0;
    else             wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (rst) begin
      ack_cnt <= 0;
    end else if (stb && ack) begin
      ack_cnt  <= ack_cnt + 1;
      last_adr <= adr;
      if (adr != BASE + 32'(4 * (ack_cnt % NPIX)) || dat_ms != exp_pix(ack_cnt % NPIX))
        seq_err <= seq_err + 1;
      if (adr - BASE < 32'(4 * NPIX))
        ram[7'((adr - BASE) >> 2)] <= dat_ms;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] a0, d0;
    int unstable, busy;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_adr", adr, BASE);
    check("rst_dat", dat_ms, 32'h0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("we_const", 32'(we), 32'd1);
    check("sel_const", 32'(sel), 32'hF);

    // Zero-latency slave: one RELEASE cycle, then streaming writes
    lat = 0;
    rst = 1'b0;
    @(negedge clk);
    check("first_cyc", 32'(cyc), 32'd1);
    check("first_adr", adr, BASE);
    check("first_dat", dat_ms, W);
    @(negedge clk);
    check("second_adr", adr, BASE + 32'd4);
    check("second_dat", dat_ms, W);

    // Burst release after 8 acks
    for (int i = 0; i < 50 && cyc; i++) @(negedge clk);
    check("burst_rel_cyc", 32'(cyc), 32'd0);
    check("burst_ack_cnt", 32'(ack_cnt), 32'd8);
    @(negedge clk);
    check("resume_cyc", 32'(cyc), 32'd1);
    check("resume_adr", adr, BASE + 32'd32);

    // End of frame
    for (int i = 0; i < 3000 && !frame_done; i++) @(negedge clk);
    check("frame_done_seen", 32'(frame_done), 32'd1);
    check("frame_last_adr", last_adr, BASE + 32'(4 * 127));
    check("frame_ack_cnt", 32'(ack_cnt), 32'(NPIX));
    check("frame_end_cyc", 32'(cyc), 32'd0);
    @(negedge clk);
    check("frame_done_pulse", 32'(frame_done), 32'd0);
`ifdef MIRE_LOOP_EN
    check("loop_cyc", 32'(cyc), 32'd1);
    check("loop_adr", adr, BASE);
`else
    busy = 0;
    for (int i = 0; i < 1000; i++) begin
      if (cyc) busy++;
      @(negedge clk);
    end
    check("idle_after_frame", 32'(busy), 32'd0);
`endif

    // RAM readback
    check("ram_x16_y0", ram[16], W);
    check("ram_x16_y1", ram[HDISP + 16], W);
    check("ram_x16_y2", ram[2 * HDISP + 16], W);
    check("ram_x5_y0", ram[5], W);
    check("ram_x1_y1", ram[HDISP + 1], 32'h0);
    check("ram_x3_y2", ram[2 * HDISP + 3], 32'h0);
    check("ram_x31_y3", ram[3 * HDISP + 31], W);
    check("ram_x31_y1", ram[HDISP + 31], W);
    check("ram_x0_y2", ram[2 * HDISP], W);

    // Latency 12: stable request through every wait cycle
    rst = 1'b1;
    lat = 12;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("lat_first_cyc", 32'(cyc), 32'd1);
    a0 = adr;
    d0 = dat_ms;
    unstable = 0;
    for (int i = 0; i < 12; i++) begin
      if (adr !== a0 || dat_ms !== d0 || ack !== 1'b0 || stb !== 1'b1) unstable++;
      @(negedge clk);
    end
    check("lat_stable", 32'(unstable), 32'd0);
    check("lat_ack_13th", 32'(ack), 32'd1);
    check("lat_first_adr", a0, BASE);
    for (int i = 0; i < 5000 && !frame_done; i++) @(negedge clk);
    check("lat_frame_done", 32'(frame_done), 32'd1);
    check("lat_ack_cnt", 32'(ack_cnt), 32'(NPIX));

    // Reset during the 5th wait cycle of the 4th write
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 200 && ack_cnt != 3; i++) @(negedge clk);
    check("mid_ack_cnt", 32'(ack_cnt), 32'd3);
    repeat (4) @(negedge clk);
    check("mid_waiting", 32'({stb, ack}), 32'b10);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cyc", 32'(cyc), 32'd0);
    check("mid_rst_stb", 32'(stb), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_cyc", 32'(cyc), 32'd1);
    check("restart_adr", adr, BASE);
    check("restart_dat", dat_ms, W);

    check("ack_sequence_errors", 32'(seq_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
